cp0_intc: RTL and testbench

Parametrised coprocessor-0 successor for the multicycle MIPS core: holds Status, Cause, EPC, Count and Compare, prioritises synchronous exceptions, and adds maskable, synchronised external interrupts, a timer interrupt, EXL nesting protection and ERET return. It sits beside the control unit. The core redirects fetch when `ex` is high and reads `epc` on ERET.

---
 rtl/cp0_intc.sv | 144 ++++++++++++++
 tb/tb_cp0_intc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// Coprocessor-0 for the multicycle MIPS core: Status/Cause/EPC/Count/Compare,
// exception prioritisation, synchronised maskable interrupts and a timer interrupt.
module cp0_intc #(
  parameter int NIRQ = 6,
  parameter int SYNC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      adr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [31:0]     pc,
  input  logic            ov,
  input  logic            dz,
  input  logic            sys,
  input  logic            brk,
  input  logic            intok,
  input  logic            eret,
  input  logic [NIRQ-1:0] irq,
  output logic            ex,
  output logic [4:0]      excode,
  output logic [31:0]     epc,
  output logic            exl
);

  localparam logic [4:0] ADR_COUNT   = 5'd9;
  localparam logic [4:0] ADR_COMPARE = 5'd11;
  localparam logic [4:0] ADR_STATUS  = 5'd12;
  localparam logic [4:0] ADR_CAUSE   = 5'd13;
  localparam logic [4:0] ADR_EPC     = 5'd14;

  logic [NIRQ-1:0] sync_reg [SYNC];
  logic            ie_reg;
  logic            exl_reg;
  logic [NIRQ:0]   im_reg;
  logic [4:0]      exccode_reg;
  logic [31:0]     epc_reg;
  logic [31:0]     count_reg;
  logic [31:0]     compare_reg;
  logic            ti_reg;

  logic [NIRQ:0]   ip;
  logic            pend;
  logic            wr_count, wr_compare, wr_status, wr_epc;
  logic [31:0]     status_rd, cause_rd;

  assign wr_count   = we && (adr == ADR_COUNT);
  assign wr_compare = we && (adr == ADR_COMPARE);
  assign wr_status  = we && (adr == ADR_STATUS);
  assign wr_epc     = we && (adr == ADR_EPC);

  // Timer request sits above the external lines in both IP and IM.
  assign ip   = {ti_reg, sync_reg[SYNC-1]};
  assign pend = ie_reg & ~exl_reg & (|(ip & im_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= irq;
      for (int i = 1; i < SYNC; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  // Synchronous exceptions outrank the interrupt; dz is highest.
  always_comb begin
    excode = 5'd0;
    if (dz)       excode = 5'd15;
    else if (ov)  excode = 5'd12;
    else if (sys) excode = 5'd8;
    else if (brk) excode = 5'd9;
  end

  assign ex = dz | ov | sys | brk | (intok & pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_reg      <= 1'b0;
      exl_reg     <= 1'b0;
      im_reg      <= '0;
      exccode_reg <= 5'd0;
      epc_reg     <= 32'd0;
    end else if (ex) begin
      exl_reg     <= 1'b1;
      exccode_reg <= excode;
      epc_reg     <= pc;
    end else begin
      if (wr_status) begin
        ie_reg <= wd[0];
        im_reg <= wd[8+NIRQ:8];
      end
      if (eret)
        exl_reg <= 1'b0;
      else if (wr_status)
        exl_reg <= wd[1];
      if (wr_epc)
        epc_reg <= wd;
    end
  end

  // Count/Compare writes are honoured even on an exception edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= 32'd0;
      compare_reg <= 32'hFFFF_FFFF;
      ti_reg      <= 1'b0;
    end else begin
      count_reg <= wr_count ? wd : count_reg + 32'd1;
      if (wr_compare)
        compare_reg <= wd;
      if (wr_compare)
        ti_reg <= 1'b0;
      else if (count_reg == compare_reg)
        ti_reg <= 1'b1;
    end
  end

  always_comb begin
    status_rd              = '0;
    status_rd[0]           = ie_reg;
    status_rd[1]           = exl_reg;
    status_rd[8+NIRQ:8]    = im_reg;
    cause_rd               = '0;
    cause_rd[6:2]          = exccode_reg;
    cause_rd[8+NIRQ:8]     = ip;
  end

  always_comb begin
    rd = 32'd0;
    case (adr)
      ADR_COUNT:   rd = count_reg;
      ADR_COMPARE: rd = compare_reg;
      ADR_STATUS:  rd = status_rd;
      ADR_CAUSE:   rd = cause_rd;
      ADR_EPC:     rd = epc_reg;
      default:     rd = 32'd0;
    endcase
  end

  assign epc = epc_reg;
  assign exl = exl_reg;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: stimulus queues expected values, a monitor
// process samples the DUT and compares them.
module tb_cp0_intc;
  localparam int NIRQ = 6;
  localparam int SYNC = 2;

  localparam int SIG_EX     = 0;
  localparam int SIG_EXCODE = 1;
  localparam int SIG_EPC    = 2;
  localparam int SIG_EXL    = 3;
  localparam int SIG_RD     = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [4:0]      adr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [31:0]     pc;
  logic            ov, dz, sys, brk, intok, eret;
  logic [NIRQ-1:0] irq;
  logic            ex;
  logic [4:0]      excode;
  logic [31:0]     epc;
  logic            exl;

  cp0_intc #(.NIRQ(NIRQ), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .we(we), .adr(adr), .wd(wd), .rd(rd), .pc(pc),
    .ov(ov), .dz(dz), .sys(sys), .brk(brk), .intok(intok), .eret(eret),
    .irq(irq), .ex(ex), .excode(excode), .epc(epc), .exl(exl)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q[$];
  event  chk_ev;
  int    pushed = 0;
  int    popped = 0;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] sample(input int s);
    case (s)
      SIG_EX:     return {31'd0, ex};
      SIG_EXCODE: return {27'd0, excode};
      SIG_EPC:    return epc;
      SIG_EXL:    return {31'd0, exl};
      default:    return rd;
    endcase
  endfunction

  // Monitor: drains the scoreboard whenever new expectations are posted.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = sample(e.sig) & e.mask;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end else begin
          $display("check %s: got %h ok", e.name, act);
        end
        popped++;
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] m, input logic [31:0] x);
    exp_q.push_back('{n, s, m, x});
    pushed++;
    -> chk_ev;
    wait (popped == pushed);
  endtask

  task automatic rdchk(input string n, input logic [4:0] a, input logic [31:0] m, input logic [31:0] x);
    adr = a;
    #1;
    chk(n, SIG_RD, m, x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; adr = 5'd0; wd = 32'd0; pc = 32'd0;
    ov = 1'b0; dz = 1'b0; sys = 1'b0; brk = 1'b0; intok = 1'b0; eret = 1'b0;
    irq = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // reset state
    chk("rst_ex", SIG_EX, 32'h1, 32'h0);
    chk("rst_excode", SIG_EXCODE, 32'h1F, 32'h0);
    chk("rst_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0);
    chk("rst_exl", SIG_EXL, 32'h1, 32'h0);
    rdchk("rst_compare", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rdchk("rst_status", 5'd12, 32'hFFFF_FFFF, 32'h0);
    rdchk("rst_cause", 5'd13, 32'hFFFF_FFFF, 32'h0);
    rdchk("rst_count", 5'd9, 32'hFFFF_FFFF, 32'h0);
    rdchk("unmapped_rd", 5'd3, 32'hFFFF_FFFF, 32'h0);

    // divide-by-zero exception
    dz = 1'b1; pc = 32'h0000_3010;
    #1;
    chk("dz_ex", SIG_EX, 32'h1, 32'h1);
    chk("dz_excode", SIG_EXCODE, 32'h1F, 32'd15);
    step();
    dz = 1'b0; pc = 32'd0;
    #1;
    chk("dz_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0000_3010);
    chk("dz_exl", SIG_EXL, 32'h1, 32'h1);
    rdchk("dz_cause_code", 5'd13, 32'h7C, 32'd15 << 2);

    // external interrupt through the synchroniser
    we = 1'b1; adr = 5'd12; wd = 32'h0000_0101;
    step();
    we = 1'b0; irq = 6'b000001; intok = 1'b1;
    #1;
    chk("irq_edge0_ex", SIG_EX, 32'h1, 32'h0);
    rdchk("status_wr", 5'd12, 32'hFFFF_FFFF, 32'h0000_0101);
    step();
    chk("irq_edge1_ex", SIG_EX, 32'h1, 32'h0);
    step();
    chk("irq_edge2_ex", SIG_EX, 32'h1, 32'h1);
    chk("irq_edge2_code", SIG_EXCODE, 32'h1F, 32'h0);
    intok = 1'b0;
    #1;
    chk("irq_no_intok", SIG_EX, 32'h1, 32'h0);

    // ov beats sys beats the pending interrupt
    ov = 1'b1; sys = 1'b1; intok = 1'b1; pc = 32'h0000_4000;
    #1;
    chk("ov_ex", SIG_EX, 32'h1, 32'h1);
    chk("ov_excode", SIG_EXCODE, 32'h1F, 32'd12);
    step();
    ov = 1'b0; sys = 1'b0; pc = 32'd0;
    #1;
    chk("exl_blocks_irq", SIG_EX, 32'h1, 32'h0);
    chk("ov_exl", SIG_EXL, 32'h1, 32'h1);
    chk("ov_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0000_4000);
    rdchk("ov_cause_code", 5'd13, 32'h7C, 32'd12 << 2);
    rdchk("ip0_visible", 5'd13, 32'h100, 32'h100);
    intok = 1'b0; irq = '0;

    // brk wins over eret
    eret = 1'b1; brk = 1'b1; pc = 32'h0000_5000;
    #1;
    chk("brk_ex", SIG_EX, 32'h1, 32'h1);
    chk("brk_excode", SIG_EXCODE, 32'h1F, 32'd9);
    step();
    eret = 1'b0; brk = 1'b0; pc = 32'd0;
    #1;
    chk("brk_exl_kept", SIG_EXL, 32'h1, 32'h1);
    chk("brk_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0000_5000);
    eret = 1'b1;
    step();
    eret = 1'b0;
    #1;
    chk("eret_exl", SIG_EXL, 32'h1, 32'h0);
    rdchk("eret_status", 5'd12, 32'hFFFF_FFFF, 32'h0000_0101);

    // Count wrap and Compare match
    we = 1'b1; adr = 5'd9; wd = 32'hFFFF_FFFE;
    step();
    adr = 5'd11; wd = 32'h0;
    step();
    we = 1'b0;
    rdchk("count_ff", 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rdchk("ti_pre0", 5'd13, 32'h4000, 32'h0);
    step();
    rdchk("count_wrap", 5'd9, 32'hFFFF_FFFF, 32'h0);
    rdchk("ti_pre1", 5'd13, 32'h4000, 32'h0);
    step();
    rdchk("ti_set", 5'd13, 32'h4000, 32'h4000);
    rdchk("count_after", 5'd9, 32'hFFFF_FFFF, 32'h1);

    // timer interrupt through IM[6]
    we = 1'b1; adr = 5'd12; wd = 32'h0000_4001;
    step();
    we = 1'b0; intok = 1'b1;
    #1;
    chk("timer_ex", SIG_EX, 32'h1, 32'h1);
    chk("timer_code", SIG_EXCODE, 32'h1F, 32'h0);
    intok = 1'b0;

    // Compare write clears TI even on a match edge
    we = 1'b1; adr = 5'd9; wd = 32'h0;
    step();
    adr = 5'd11; wd = 32'h50;
    step();
    we = 1'b0; intok = 1'b1;
    rdchk("ti_cleared", 5'd13, 32'h4000, 32'h0);
    chk("timer_ex_gone", SIG_EX, 32'h1, 32'h0);
    rdchk("compare_wr", 5'd11, 32'hFFFF_FFFF, 32'h50);
    intok = 1'b0;

    // exception edge still loads Count, then async reset mid-handler
    dz = 1'b1; pc = 32'h0000_6000; we = 1'b1; adr = 5'd9; wd = 32'd100;
    #1;
    chk("dz2_ex", SIG_EX, 32'h1, 32'h1);
    step();
    dz = 1'b0; we = 1'b0; pc = 32'd0;
    rdchk("count_100", 5'd9, 32'hFFFF_FFFF, 32'd100);
    chk("dz2_exl", SIG_EXL, 32'h1, 32'h1);
    chk("dz2_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0000_6000);
    rst = 1'b1;
    #1;
    chk("arst_exl", SIG_EXL, 32'h1, 32'h0);
    chk("arst_epc", SIG_EPC, 32'hFFFF_FFFF, 32'h0);
    chk("arst_count", SIG_RD, 32'hFFFF_FFFF, 32'h0);
    rdchk("arst_compare", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rdchk("arst_status", 5'd12, 32'hFFFF_FFFF, 32'h0);
    chk("arst_ex", SIG_EX, 32'h1, 32'h0);
    rst = 1'b0;
    #5;

    if (exp_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
